// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Round-robin arbitration on contention, with a registered memory interface and one-cycle done pulses.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                mem_ce,
  output logic                mem_oe,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // On a tie the requester that did not own the last access wins.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    case (state)
      IDLE: begin
        if (!Reset) begin
          if (if_req && (!d_req || owner)) if_gnt = 1'b1;
          else if (d_req)                  d_gnt  = 1'b1;
        end
        if (if_gnt || d_gnt) state_next = ACCESS;
      end
      ACCESS:  if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Enables drop on the edge into DONE so they are low while the done pulse is shown.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner     <= 1'b1;
      cnt       <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_ce    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt) begin
            owner    <= 1'b0;
            mem_addr <= if_addr;
            mem_be   <= {BE_W{1'b1}};
            mem_ce   <= 1'b1;
            mem_oe   <= 1'b1;
            mem_we   <= 1'b0;
            cnt      <= CNT_INIT;
          end else if (d_gnt) begin
            owner     <= 1'b1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_we ? d_be : {BE_W{1'b1}};
            mem_ce    <= 1'b1;
            mem_oe    <= !d_we;
            mem_we    <= d_we;
            cnt       <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_ce <= 1'b0;
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_we) begin
              if (owner) d_rdata  <= mem_rdata;
              else       if_rdata <= mem_rdata;
            end
            if (owner) d_done  <= 1'b1;
            else       if_done <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants push expected completions and done pulses pop them.
// Directed sequences cover timing, stores, contention, reset abort and dropped requests.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ce, mem_oe, mem_we, busy, owner;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  int          grant_cyc[$];
  int          grant_who[$];
  logic [31:0] mem_model [0:255];
  logic [31:0] ref_mem   [0:255];
  logic [31:0] exp_if, exp_d;
  int          cyc, if_gnt_count, d_done_count;
  int          checks, errors;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYCLES(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] initWord(input int i);
    if (i == 4)  return 32'h0000_0093;
    if (i == 64) return 32'h1234_5678;
    return 32'h1000_0000 + i * 32'h0000_0101;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: combinational read while output-enabled, byte-masked write on each enabled edge.
  assign mem_rdata = mem_oe ? mem_model[mem_addr[9:2]] : 32'h0;

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = initWord(i);
    forever begin
      @(posedge Clk);
      if (mem_ce && mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_model[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    sb_t e;
    for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);
    exp_if = 32'h0;
    exp_d  = 32'h0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Reset) begin
        sb.delete();
        exp_if = 32'h0;
        exp_d  = 32'h0;
      end else begin
        if (if_gnt) begin
          if_gnt_count++;
          grant_cyc.push_back(cyc);
          grant_who.push_back(0);
          sb.push_back('{owner: 1'b0, wr: 1'b0, data: ref_mem[if_addr[9:2]]});
        end
        if (d_gnt) begin
          grant_cyc.push_back(cyc);
          grant_who.push_back(1);
          if (d_we) begin
            for (int b = 0; b < 4; b++)
              if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
            sb.push_back('{owner: 1'b1, wr: 1'b1, data: 32'h0});
          end else begin
            sb.push_back('{owner: 1'b1, wr: 1'b0, data: ref_mem[d_addr[9:2]]});
          end
        end
        if (if_done || d_done) begin
          if (d_done) d_done_count++;
          checkOutput("done_exclusive", {31'b0, if_done & d_done}, 32'h0);
          if (sb.size() == 0) begin
            checkOutput("sb_unexpected_done", 32'h1, 32'h0);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_done_owner", {31'b0, d_done}, {31'b0, e.owner});
            checkOutput("sb_owner_reg", {31'b0, owner}, {31'b0, e.owner});
            if (!e.wr) begin
              if (e.owner) exp_d  = e.data;
              else         exp_if = e.data;
            end
          end
          checkOutput("sb_if_rdata", if_rdata, exp_if);
          checkOutput("sb_d_rdata", d_rdata, exp_d);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] dbe);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    d_be    = dbe;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge Clk);
    while (busy && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 32'h0, 32'h1);
    step();
  endtask

  initial begin
    int gcyc, base, n, cnt_before;
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    @(negedge Clk);
    checkOutput("rst_ctrl", {busy, mem_ce, mem_oe, mem_we, if_done, d_done, if_gnt, d_gnt}, 32'h0);
    checkOutput("rst_owner", {31'b0, owner}, 32'h1);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_be", {28'h0, mem_be}, 32'h0);
    checkOutput("rst_rdata", if_rdata | d_rdata | mem_wdata, 32'h0);

    // Single fetch straight out of reset.
    step();
    Reset = 1'b0;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge Clk);
    checkOutput("t1_if_gnt", {31'b0, if_gnt}, 32'h1);
    step();
    if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("t1_ce_oe_we", {29'b0, mem_ce, mem_oe, mem_we}, 32'h6);
      checkOutput("t1_mem_addr", mem_addr, 32'h10);
      step();
    end
    @(negedge Clk);
    checkOutput("t1_if_done", {31'b0, if_done}, 32'h1);
    checkOutput("t1_if_rdata", if_rdata, 32'h93);
    checkOutput("t1_done_enables", {29'b0, mem_ce, mem_oe, mem_we}, 32'h0);
    step();
    @(negedge Clk);
    checkOutput("t1_idle", {30'b0, busy, if_done}, 32'h0);

    // Partial store.
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    cnt_before = d_done_count;
    @(negedge Clk);
    checkOutput("t2_d_gnt", {30'b0, if_gnt, d_gnt}, 32'h1);
    step();
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("t2_ce_oe_we", {29'b0, mem_ce, mem_oe, mem_we}, 32'h5);
      checkOutput("t2_mem_be", {28'h0, mem_be}, 32'h3);
      step();
    end
    @(negedge Clk);
    checkOutput("t2_d_done", {31'b0, d_done}, 32'h1);
    checkOutput("t2_d_rdata_kept", d_rdata, 32'h0);
    checkOutput("t2_mem_word", mem_model[64], 32'h1234_BEEF);
    waitIdle();
    checkOutput("t2_done_once", d_done_count - cnt_before, 32'h1);

    // Load raised one cycle after a fetch grant waits for the fetch to finish.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge Clk);
    checkOutput("t4_if_gnt", {31'b0, if_gnt}, 32'h1);
    gcyc = cyc;
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    n = 0;
    @(negedge Clk);
    while (!d_gnt && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("t4_d_gnt_seen", {31'b0, d_gnt}, 32'h1);
    checkOutput("t4_gnt_spacing", cyc - gcyc, 32'd5);
    step();
    d_req = 1'b0;
    waitIdle();
    checkOutput("t4_d_rdata", d_rdata, 32'h1234_BEEF);
    checkOutput("t4_if_rdata", if_rdata, initWord(8));

    // Fetch request pulsed during a data access is not served.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    cnt_before = if_gnt_count;
    step();
    d_req = 1'b0;
    step();
    if_req  = 1'b1;
    if_addr = 32'h30;
    step();
    if_req = 1'b0;
    waitIdle();
    @(negedge Clk);
    checkOutput("t6_busy_low", {31'b0, busy}, 32'h0);
    step();
    step();
    checkOutput("t6_no_fetch", if_gnt_count - cnt_before, 32'h0);

    // Reset in the second ACCESS cycle of a store aborts it.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 4'hF);
    cnt_before = d_done_count;
    step();
    d_req = 1'b0;
    step();
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("t5_we_before", {31'b0, mem_we}, 32'h1);
    step();
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("t5_abort", {29'b0, mem_we, mem_ce, busy}, 32'h0);
    checkOutput("t5_owner", {31'b0, owner}, 32'h1);
    for (int i = 0; i < 6; i++) step();
    checkOutput("t5_no_done", d_done_count - cnt_before, 32'h0);

    // Both requesters held from reset alternate, fetch first.
    Reset = 1'b1;
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step();
    step();
    base = grant_cyc.size();
    Reset = 1'b0;
    n = 0;
    while (grant_cyc.size() < base + 4 && n < 40) begin
      step();
      n++;
    end
    if (grant_cyc.size() < base + 4) begin
      checkOutput("t3_grant_timeout", grant_cyc.size() - base, 32'd4);
    end else begin
      for (int k = 0; k < 4; k++)
        checkOutput("t3_grant_order", grant_who[base+k], k % 2);
      for (int k = 0; k < 3; k++)
        checkOutput("t3_grant_spacing", grant_cyc[base+k+1] - grant_cyc[base+k], 32'd5);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    waitIdle();
    checkOutput("t3_sb_drained", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory port between the instruction-fetch requester and the load/store requester of the multicycle RISC-V core. It arbitrates requests with round-robin on contention and latches the winner's address, data and byte enables. It drives a fixed-latency memory access and returns read data with a one-cycle completion pulse. It replaces the hard-coded memory wait states in the control FSM; fetch and load/store states now wait on completion pulses.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width (byte enables are DATA_W/8 bits)
- ACCESS_CYCLES, 3, cycles the memory needs with enables held; legal range 1..15
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  Reset, synchronous, active-high; clock Clk
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant; if_addr latched on this edge
- if_done  out  1  one-cycle pulse; if_rdata valid from this cycle
- if_rdata  out  DATA_W  fetched word, held until next fetch completes
- d_req  in  1  load/store request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables (ignored for loads)
- d_gnt  out  1  one-cycle grant; d_* latched on this edge
- d_done  out  1  one-cycle pulse at end of load or store
- d_rdata  out  DATA_W  load data, held until next load completes
- mem_addr  out  ADDR_W  latched address to memory
- mem_wdata  out  DATA_W  latched store data
- mem_be  out  DATA_W/8  byte enables (all ones for fetch and load)
- mem_ce, mem_oe, mem_we  out  1 each  chip, output and write enables
- mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle
- busy  out  1  high whenever state is not IDLE
- owner  out  1  0 = fetch, 1 = data; owner of current or last access

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: when no request is pending, stay in IDLE.
- IDLE, exactly one request: grant it.
- IDLE, both requests: grant the requester that is not owner, so requesters alternate.
- Grant cycle: assert the grant combinationally. On the edge, latch the request fields, set owner, load the counter with ACCESS_CYCLES-1 and go to ACCESS.
- ACCESS: mem_ce=1. Read: mem_oe=1, mem_we=0. Write: mem_oe=0, mem_we=1. mem_addr, mem_wdata and mem_be come only from the latched registers.
- ACCESS counter: decrement each cycle. At count 0 on a read, capture mem_rdata into if_rdata or d_rdata (selected by owner), then go to DONE.
- DONE: assert if_done or d_done for one cycle, deassert the memory enables, then return to IDLE.
- Request handling: a request is sampled only in IDLE. A requester that drops its request before the grant gets no access. A request raised during another access waits for IDLE. No request is queued beyond its held level.
- Width rules: counter is 4 bits. For fetch, mem_be is all ones and mem_wdata keeps its previous value. Stores leave d_rdata unchanged.

## Timing
- Reset values: state IDLE; owner=1 (fetch wins the first tie); mem_ce, mem_oe, mem_we, if_gnt, d_gnt, if_done, d_done, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; mem_be = 0.
- Grant at cycle T. ACCESS occupies T+1 .. T+ACCESS_CYCLES. The done pulse and valid rdata fall at T+ACCESS_CYCLES+1. The earliest next grant is T+ACCESS_CYCLES+2.
- Throughput is one access per ACCESS_CYCLES+2 cycles.
- Grants are combinational from IDLE and the request inputs. All other outputs are registered.
- Reset in ACCESS or DONE: abort at the next edge. The memory enables drop and no done pulse is issued. A partially completed store is the software's problem.
- Both requests asserted in the same cycle as the DONE→IDLE transition: arbitration happens in the following IDLE cycle using the updated owner.

## Test plan
- Reset, then if_req=1, if_addr=0x0000_0010, memory word 0x0000_0093.
  - if_gnt in cycle 1.
  - mem_ce=1 and mem_oe=1 for 3 cycles.
  - if_done in cycle 5 with if_rdata=0x0000_0093.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=4'b0011.
  - mem_we=1 for 3 cycles, mem_be=0011.
  - Memory word 0x100 low half becomes 0xBEEF.
  - d_done pulses once; d_rdata is unchanged.
- if_req and d_req asserted together from reset and held re-asserted.
  - Grant order: fetch, data, fetch, data.
  - Grants are 5 cycles apart.
- d_req raised 1 cycle after if_gnt: d_gnt comes 5 cycles after if_gnt. The load returns memory[d_addr] while if_rdata holds the fetch word.
- Reset asserted in the second ACCESS cycle of a store:
  - Next cycle: mem_we=0, state IDLE.
  - No d_done.
  - owner returns to 1.
- if_req pulsed high for 1 cycle during a data access and then dropped: no fetch access occurs and busy falls after DONE.
